// File: rtl/weight_loader.sv
// Loads a valid/ready byte stream into the bias/weights BRAM through port A,
// with an optional read-back pass that checks a 16-bit additive checksum.
module weight_loader #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned ADDR_WIDTH   = 19,
  parameter int unsigned READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic                  verify,
  input  logic                  s_valid,
  input  logic [DATA_SIZE-1:0]  s_data,
  output logic                  s_ready,
  output logic                  bias_weights_bram_ena,
  output logic                  bias_weights_bram_wea,
  output logic [ADDR_WIDTH-1:0] bias_weights_bram_addra,
  output logic [DATA_SIZE-1:0]  bias_weights_bram_dina,
  input  logic [DATA_SIZE-1:0]  bias_weights_bram_douta,
  output logic                  load_finish,
  output logic [15:0]           checksum,
  output logic                  verify_error
);

  localparam int unsigned WAIT_W = $clog2(READ_LATENCY + 1);
  localparam int unsigned SUM_W  = 16;

  typedef enum logic [5:0] {
    S_IDLE         = 6'b000001,
    S_WAIT_DATA    = 6'b000010,
    S_WRITE        = 6'b000100,
    S_VERIFY_ISSUE = 6'b001000,
    S_VERIFY_WAIT  = 6'b010000,
    S_DONE         = 6'b100000
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic                  verify_q;
  logic [ADDR_WIDTH-1:0] count;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [SUM_W-1:0]      vsum;

  logic [ADDR_WIDTH-1:0] count_inc;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic [SUM_W-1:0]      vsum_next;
  logic                  last;
  logic                  frozen;

  assign s_ready   = (state == S_WAIT_DATA) && load_en;
  assign count_inc = count + ADDR_WIDTH'(1);
  assign addr_cur  = ADDR_WIDTH'(base_q + count);
  assign vsum_next = vsum + SUM_W'(bias_weights_bram_douta);
  assign last      = (count_inc == len_q);
  // Dropping load_en mid-transfer pauses everything; idle/done react to it instead.
  assign frozen    = !load_en && (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= S_IDLE;
      base_q                  <= '0;
      len_q                   <= '0;
      verify_q                <= 1'b0;
      count                   <= '0;
      wait_cnt                <= '0;
      vsum                    <= '0;
      bias_weights_bram_ena   <= 1'b0;
      bias_weights_bram_wea   <= 1'b0;
      bias_weights_bram_addra <= '0;
      bias_weights_bram_dina  <= '0;
      load_finish             <= 1'b0;
      checksum                <= '0;
      verify_error            <= 1'b0;
    end else if (!frozen) begin
      unique case (state)
        S_IDLE: begin
          bias_weights_bram_ena <= 1'b0;
          bias_weights_bram_wea <= 1'b0;
          if (load_en) begin
            base_q       <= base_addr;
            len_q        <= length;
            verify_q     <= verify;
            count        <= '0;
            checksum     <= '0;
            verify_error <= 1'b0;
            load_finish  <= 1'b0;
            state        <= (length == '0) ? S_DONE : S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (s_valid && s_ready) begin
            bias_weights_bram_ena   <= 1'b1;
            bias_weights_bram_wea   <= 1'b1;
            bias_weights_bram_addra <= addr_cur;
            bias_weights_bram_dina  <= s_data;
            checksum                <= checksum + SUM_W'(s_data);
            state                   <= S_WRITE;
          end else begin
            bias_weights_bram_ena <= 1'b0;
            bias_weights_bram_wea <= 1'b0;
          end
        end
        S_WRITE: begin
          bias_weights_bram_ena <= 1'b0;
          bias_weights_bram_wea <= 1'b0;
          count                 <= count_inc;
          if (last) begin
            if (verify_q) begin
              count <= '0;
              vsum  <= '0;
              state <= S_VERIFY_ISSUE;
            end else begin
              state <= S_DONE;
            end
          end else begin
            state <= S_WAIT_DATA;
          end
        end
        S_VERIFY_ISSUE: begin
          bias_weights_bram_ena   <= 1'b1;
          bias_weights_bram_wea   <= 1'b0;
          bias_weights_bram_addra <= addr_cur;
          wait_cnt                <= WAIT_W'(1);
          state                   <= S_VERIFY_WAIT;
        end
        S_VERIFY_WAIT: begin
          if (wait_cnt < WAIT_W'(READ_LATENCY)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            vsum                  <= vsum_next;
            bias_weights_bram_ena <= 1'b0;
            count                 <= count_inc;
            if (last) begin
              verify_error <= (vsum_next != checksum);
              state        <= S_DONE;
            end else begin
              state <= S_VERIFY_ISSUE;
            end
          end
        end
        S_DONE: begin
          bias_weights_bram_ena <= 1'b0;
          bias_weights_bram_wea <= 1'b0;
          if (load_en) begin
            load_finish <= 1'b1;
          end else begin
            load_finish <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: BRAM model, expected-access scoreboard
// and per-load result model derived from the block's rules.
module tb_weight_loader;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;
  localparam logic [AW-1:0] CORR_ADDR = 19'd25502;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          verify = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          ena, wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [DW-1:0] douta = '0;
  logic          load_finish;
  logic [15:0]   checksum;
  logic          verify_error;

  int   vectors = 0;
  int   miscompares = 0;
  acc_t exp_q[$];
  logic [DW-1:0] blk [0:15];
  logic corrupt = 1'b0;

  bit   [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd1 = '0;

  weight_loader #(.DATA_SIZE(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .base_addr(base_addr),
    .length(length), .verify(verify), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .bias_weights_bram_ena(ena), .bias_weights_bram_wea(wea),
    .bias_weights_bram_addra(addra), .bias_weights_bram_dina(dina),
    .bias_weights_bram_douta(douta), .load_finish(load_finish),
    .checksum(checksum), .verify_error(verify_error)
  );

  always #5 clk = ~clk;

  // Two-register read pipeline: data valid three edges after ena is registered.
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= (corrupt && addra == CORR_ADDR) ? 8'h04 : dina;
    if (ena) rd1 <= mem[addra];
    douta <= rd1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Per-cycle monitor: every new BRAM access must match the next expected one.
  initial begin
    acc_t e, g;
    logic prev_ena;
    prev_ena = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rst) begin
        prev_ena = 1'b0;
      end else begin
        if (ena && !prev_ena) begin
          g = '{we: wea, addr: addra, data: (wea ? dina : 8'h00)};
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL access: got we=%0d addr=%0d data=%h, required no access", wea, addra, g.data);
          end else begin
            e = exp_q.pop_front();
            if (g != e) begin
              miscompares++;
              $display("FAIL access: got we=%0d addr=%0d data=%h, required we=%0d addr=%0d data=%h",
                       g.we, g.addr, g.data, e.we, e.addr, e.data);
            end
          end
        end
        if (ena && wea) check("ready_in_write", 64'(s_ready), 64'd0);
        if (load_finish) check("ena_in_done", 64'(ena), 64'd0);
        prev_ena = ena;
      end
    end
  end

  task automatic run_load(input logic [AW-1:0] b, input logic [AW-1:0] len, input logic v,
                          input int gap, input int frz_at, output int lat);
    int idx, n, stall;
    logic [AW-1:0] a, snap;
    logic [15:0] cs, vs;
    idx = 0; n = 0; stall = 0; cs = '0; vs = '0; snap = '0; lat = -1;
    for (int i = 0; i < int'(len); i++) begin
      a = b + AW'(i);
      exp_q.push_back('{we: 1'b1, addr: a, data: blk[i]});
      cs = cs + 16'(blk[i]);
      vs = vs + 16'((corrupt && a == CORR_ADDR) ? 8'h04 : blk[i]);
    end
    if (v) for (int i = 0; i < int'(len); i++)
      exp_q.push_back('{we: 1'b0, addr: b + AW'(i), data: 8'h00});
    forever begin
      @(negedge clk);
      base_addr = b; length = len; verify = v;
      load_en = !(frz_at >= 0 && n >= frz_at && n < frz_at + 4);
      s_valid = (idx < int'(len)) && (stall == 0);
      s_data  = s_valid ? blk[idx] : 8'($urandom);
      #1;
      if (frz_at >= 0 && n == frz_at) snap = addra;
      if (frz_at >= 0 && n > frz_at && n <= frz_at + 4) check("freeze_addr", 64'(addra), 64'(snap));
      if (!load_en) check("frozen_ready", 64'(s_ready), 64'd0);
      if (s_valid && s_ready) begin
        idx++;
        stall = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      end else if (!s_valid && stall > 0) begin
        stall--;
      end
      if (load_finish) begin
        lat = n - 1;
        break;
      end
      n++;
      if (n > 3000) begin
        check("finish_timeout", 64'd0, 64'd1);
        break;
      end
    end
    s_valid = 1'b0;
    check("checksum", 64'(checksum), 64'(cs));
    check("verify_error", 64'(verify_error), 64'(v && (vs != cs)));
    if (gap == 0)
      check("latency", 64'(lat), 64'(1 + 2 * int'(len) + (v ? 4 * int'(len) : 0) + (frz_at >= 0 ? 4 : 0)));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("finish_held", 64'(load_finish), 64'd1);
    end
    @(negedge clk); load_en = 1'b0;
    @(negedge clk); #1;
    check("finish_clear", 64'(load_finish), 64'd0);
    check("accesses_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int lat, idx;
    logic [AW-1:0] rb, rl;
    logic rv;
    int rg;
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset_initial", {s_ready, ena, wea, addra, dina, load_finish, checksum, verify_error}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Reset in the middle of a load, after two of four bytes.
    blk[0] = 8'h11; blk[1] = 8'h22; blk[2] = 8'h33; blk[3] = 8'h44;
    for (int i = 0; i < 4; i++) exp_q.push_back('{we: 1'b1, addr: AW'(300 + i), data: blk[i]});
    base_addr = 19'd300; length = 19'd4; verify = 1'b0; idx = 0;
    for (int c = 0; c < 100 && idx < 2; c++) begin
      @(negedge clk);
      load_en = 1'b1; s_valid = 1'b1; s_data = blk[idx];
      #1;
      if (s_valid && s_ready) idx++;
    end
    @(negedge clk);
    s_valid = 1'b0; rst = 1'b0; #1;
    check("reset_midload", {s_ready, ena, wea, addra, dina, load_finish, checksum, verify_error}, 64'd0);
    load_en = 1'b0; exp_q.delete();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    blk[0] = 8'h5A;
    run_load(19'd100, 19'd1, 1'b0, 0, -1, lat);
    check("lit_restart_cs", 64'(checksum), 64'h005A);

    blk[0] = 8'h01; blk[1] = 8'h02; blk[2] = 8'h03; blk[3] = 8'hFF;
    run_load(19'd25500, 19'd4, 1'b0, 0, -1, lat);
    check("lit_plain_cs", 64'(checksum), 64'h0105);
    check("lit_plain_lat", 64'(lat), 64'd9);

    run_load(19'd25500, 19'd4, 1'b1, 0, -1, lat);
    check("lit_verify_lat", 64'(lat), 64'd25);
    check("lit_verify_err", 64'(verify_error), 64'd0);

    corrupt = 1'b1;
    run_load(19'd25500, 19'd4, 1'b1, 0, -1, lat);
    check("lit_corrupt_err", 64'(verify_error), 64'd1);
    corrupt = 1'b0;

    run_load(19'd777, 19'd0, 1'b1, 0, -1, lat);
    check("lit_zero_lat", 64'(lat), 64'd1);
    check("lit_zero_cs", 64'(checksum), 64'd0);

    blk[0] = 8'hA1; blk[1] = 8'hB2; blk[2] = 8'hC3;
    run_load(19'd524286, 19'd3, 1'b1, 5, -1, lat);
    check("lit_wrap_cs", 64'(checksum), 64'h0216);

    blk[0] = 8'h01; blk[1] = 8'h02; blk[2] = 8'h03; blk[3] = 8'hFF;
    run_load(19'd25500, 19'd4, 1'b1, 0, 14, lat);
    check("lit_freeze_lat", 64'(lat), 64'd29);
    check("lit_freeze_cs", 64'(checksum), 64'h0105);
    check("lit_freeze_err", 64'(verify_error), 64'd0);

    for (int t = 0; t < 10; t++) begin
      rb = AW'($urandom);
      rl = AW'($urandom_range(1, 12));
      rv = 1'($urandom_range(0, 1));
      rg = ($urandom_range(0, 1) == 0) ? 0 : -1;
      for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
      run_load(rb, rl, rv, rg, -1, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
